// File: rtl/brush_stamp_sequencer.sv
// Brush stamp sequencer: walks the lattice points of a filled disc centred
// on the cursor and emits one frame-buffer pixel write per on-screen point
// over a valid/ready handshake. Candidates are visited row-major, one per
// cycle, with at most one pixel every two cycles.
module brush_stamp_sequencer #(
  parameter int MAX_RADIUS  = 10,
  parameter int X_WIDTH     = 10,
  parameter int Y_WIDTH     = 9,
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int COLOR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stamp_req,
  input  logic [X_WIDTH-1:0]     stamp_x,
  input  logic [Y_WIDTH-1:0]     stamp_y,
  input  logic [4:0]             radius,
  input  logic [COLOR_WIDTH-1:0] color,
  output logic                   busy,
  output logic                   done,
  output logic                   pix_valid,
  input  logic                   pix_ready,
  output logic [X_WIDTH-1:0]     pix_x,
  output logic [Y_WIDTH-1:0]     pix_y,
  output logic [COLOR_WIDTH-1:0] pix_color
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  localparam logic [4:0]                 R_MAX = 5'(MAX_RADIUS);
  localparam logic signed [X_WIDTH:0]    X_LIM = (X_WIDTH+1)'(SCREEN_W);
  localparam logic signed [Y_WIDTH:0]    Y_LIM = (Y_WIDTH+1)'(SCREEN_H);

  state_t                 state;
  logic [X_WIDTH-1:0]     cx;
  logic [Y_WIDTH-1:0]     cy;
  logic [4:0]             r;
  logic [COLOR_WIDTH-1:0] col;
  logic signed [5:0]      dx;
  logic signed [5:0]      dy;

  logic [4:0]             r_clamp;
  logic signed [5:0]      r_s;
  logic [4:0]             adx;
  logic [4:0]             ady;
  logic [7:0]             sq_dx;
  logic [7:0]             sq_dy;
  logic [7:0]             sq_r;
  logic [8:0]             dist2;
  logic signed [X_WIDTH:0] px;
  logic signed [Y_WIDTH:0] py;
  logic                   in_x;
  logic                   in_y;
  logic                   hit;
  logic                   last;
  logic signed [5:0]      dx_nxt;
  logic signed [5:0]      dy_nxt;

  // Candidate evaluation: distance test, screen clipping and counter advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    r_clamp = (radius > R_MAX) ? R_MAX : radius;
    r_s     = signed'({1'b0, r});
    adx     = dx[5] ? 5'(-dx) : 5'(dx);
    ady     = dy[5] ? 5'(-dy) : 5'(dy);
    sq_dx   = {3'b000, adx} * {3'b000, adx};
    sq_dy   = {3'b000, ady} * {3'b000, ady};
    sq_r    = {3'b000, r} * {3'b000, r};
    dist2   = {1'b0, sq_dx} + {1'b0, sq_dy};
    px      = signed'({1'b0, cx}) + {{(X_WIDTH-5){dx[5]}}, dx};
    py      = signed'({1'b0, cy}) + {{(Y_WIDTH-5){dy[5]}}, dy};
    in_x    = !px[X_WIDTH] && (px < X_LIM);
    in_y    = !py[Y_WIDTH] && (py < Y_LIM);
    hit     = (dist2 <= {1'b0, sq_r}) && in_x && in_y;
    last    = (dx == r_s) && (dy == r_s);
    dx_nxt  = dx + 6'sd1;
    dy_nxt  = dy;
    if (dx == r_s) begin
      dx_nxt = -r_s;
      dy_nxt = dy + 6'sd1;
    end
  end

  // Stamp FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_color <= '0;
      cx        <= '0;
      cy        <= '0;
      r         <= '0;
      col       <= '0;
      dx        <= '0;
      dy        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (stamp_req) begin
            cx    <= stamp_x;
            cy    <= stamp_y;
            r     <= r_clamp;
            col   <= color;
            dx    <= -signed'({1'b0, r_clamp});
            dy    <= -signed'({1'b0, r_clamp});
            busy  <= 1'b1;
            state <= SCAN;
          end
        end
        SCAN: begin
          if (hit) begin
            pix_x     <= px[X_WIDTH-1:0];
            pix_y     <= py[Y_WIDTH-1:0];
            pix_color <= col;
            pix_valid <= 1'b1;
            state     <= EMIT;
          end else begin
            dx <= dx_nxt;
            dy <= dy_nxt;
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        EMIT: begin
          if (pix_ready) begin
            pix_valid <= 1'b0;
            dx        <= dx_nxt;
            dy        <= dy_nxt;
            if (last) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= SCAN;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brush_stamp_sequencer.sv
// Testbench for brush_stamp_sequencer: each scenario drives stamps and
// compares the pixel stream against a disc model built from plain arithmetic.
module tb_brush_stamp_sequencer;

  typedef struct {
    int x;
    int y;
  } pt_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stamp_req = 1'b0;
  logic [9:0]  stamp_x = '0;
  logic [8:0]  stamp_y = '0;
  logic [4:0]  radius = '0;
  logic [11:0] color = '0;
  logic        busy;
  logic        done;
  logic        pix_valid;
  logic        pix_ready = 1'b0;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [11:0] pix_color;

  int checks = 0;
  int errors = 0;

  brush_stamp_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stamp_req (stamp_req),
    .stamp_x   (stamp_x),
    .stamp_y   (stamp_y),
    .radius    (radius),
    .color     (color),
    .busy      (busy),
    .done      (done),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color)
  );

  always #5 clk = ~clk;

  // Runs one stamp and checks every handshake against the disc model.
  task automatic run_stamp(input int cx, input int cy, input int rad, input int col,
                           input bit rand_ready, input bit poke_req, input string name,
                           output int nwr);
    pt_t exp_q[$];
    pt_t e;
    int  r;
    int  ndone;
    int  exp_total;
    bit  stall;
    bit  fin;
    logic [9:0]  hx;
    logic [8:0]  hy;
    logic [11:0] hc;
    r = (rad > 10) ? 10 : rad;
    for (int dy = -r; dy <= r; dy++)
      for (int dx = -r; dx <= r; dx++)
        if (dx*dx + dy*dy <= r*r && cx+dx >= 0 && cx+dx < 640 && cy+dy >= 0 && cy+dy < 480)
          exp_q.push_back('{cx+dx, cy+dy});
    exp_total = exp_q.size();
    nwr = 0; ndone = 0; stall = 0; fin = 0;
    hx = '0; hy = '0; hc = '0;

    @(negedge clk);
    stamp_x = 10'(cx); stamp_y = 9'(cy); radius = 5'(rad); color = 12'(col);
    stamp_req = 1'b1; pix_ready = 1'b0;
    @(negedge clk);
    stamp_req = 1'b0;
    stamp_x = 10'($urandom); stamp_y = 9'($urandom);
    radius = 5'($urandom); color = 12'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
    end

    for (int cyc = 0; cyc < 5000 && !fin; cyc++) begin
      if (stall) begin
        checks++;
        if (pix_valid !== 1'b1 || pix_x !== hx || pix_y !== hy || pix_color !== hc) begin
          errors++;
          $display("FAIL %s stall_hold: got v=%b (%0d,%0d,%h) want v=1 (%0d,%0d,%h)",
                   name, pix_valid, pix_x, pix_y, pix_color, hx, hy, hc);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        fin = 1;
        stamp_req = 1'b0;
      end else begin
        pix_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (poke_req) begin
          stamp_req = 1'($urandom_range(0, 1));
          stamp_x = 10'($urandom); radius = 5'($urandom); color = 12'($urandom);
        end
        if (pix_valid === 1'b1 && pix_ready) begin
          nwr++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s extra_write: got (%0d,%0d) want none", name, pix_x, pix_y);
          end else begin
            e = exp_q.pop_front();
            if (int'(pix_x) != e.x || int'(pix_y) != e.y || int'(pix_color) != col) begin
              errors++;
              $display("FAIL %s pixel: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                       name, pix_x, pix_y, pix_color, e.x, e.y, col[11:0]);
            end
          end
        end
        stall = (pix_valid === 1'b1) && !pix_ready;
        hx = pix_x; hy = pix_y; hc = pix_color;
      end
      @(negedge clk);
    end

    checks++;
    if (!fin) begin
      errors++; $display("FAIL %s timeout: got no done want done", name);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL %s after_done: got busy=%b done=%b want 0 0", name, busy, done);
    end
    checks++;
    if (nwr != exp_total) begin
      errors++; $display("FAIL %s write_count: got %0d want %0d", name, nwr, exp_total);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    checks++;
    if (ndone != 1) begin
      errors++; $display("FAIL %s done_pulses: got %0d want 1", name, ndone);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pix_valid !== 1'b0 ||
        pix_x !== '0 || pix_y !== '0 || pix_color !== '0) begin
      errors++;
      $display("FAIL reset_state: got busy=%b done=%b v=%b (%0d,%0d,%h) want all 0",
               busy, done, pix_valid, pix_x, pix_y, pix_color);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_point;
    int n;
    run_stamp(100, 100, 0, 12'h5a5, 0, 0, "r0_centre", n);
    checks++;
    if (n != 1) begin errors++; $display("FAIL r0_count: got %0d want 1", n); end
  endtask

  task automatic test_small_disc;
    int n;
    run_stamp(100, 100, 1, 12'h0f3, 0, 0, "r1_disc", n);
    checks++;
    if (n != 5) begin errors++; $display("FAIL r1_count: got %0d want 5", n); end
  endtask

  task automatic test_corner_clip;
    int n;
    run_stamp(0, 0, 2, 12'hc01, 1, 0, "r2_corner", n);
    checks++;
    if (n != 6) begin errors++; $display("FAIL r2_count: got %0d want 6", n); end
  endtask

  task automatic test_large_stall;
    int n;
    run_stamp(320, 240, 10, 12'h7e4, 1, 0, "r10_stall", n);
    checks++;
    if (n != 317) begin errors++; $display("FAIL r10_count: got %0d want 317", n); end
  endtask

  task automatic test_clamp_ignore_req;
    int n;
    run_stamp(320, 240, 25, 12'h3b9, 1, 1, "clamp_poke", n);
    checks++;
    if (n != 317) begin errors++; $display("FAIL clamp_count: got %0d want 317", n); end
  endtask

  task automatic test_offscreen;
    int n;
    run_stamp(1000, 500, 5, 12'hfff, 1, 0, "offscreen", n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL offscreen_count: got %0d want 0", n); end
  endtask

  task automatic test_random;
    int n;
    int cx;
    int cy;
    for (int i = 0; i < 8; i++) begin
      cx = (i % 2 == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(630, 649));
      cy = (i % 3 == 0) ? int'($urandom_range(0, 511)) : int'($urandom_range(0, 12));
      run_stamp(cx, cy, int'($urandom_range(0, 31)), int'($urandom_range(0, 4095)),
                1, i % 2 == 1, "random", n);
    end
  endtask

  task automatic test_back_to_back;
    int t_first;
    int t_second;
    @(negedge clk);
    stamp_x = 10'd50; stamp_y = 9'd50; radius = 5'd0; color = 12'h123;
    pix_ready = 1'b1; stamp_req = 1'b1;
    t_first = -1; t_second = -1;
    for (int cyc = 0; cyc < 40 && t_second < 0; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (t_first < 0) t_first = cyc;
        else begin t_second = cyc; stamp_req = 1'b0; end
      end
    end
    stamp_req = 1'b0;
    checks++;
    if (t_first < 0 || t_second - t_first != 4) begin
      errors++;
      $display("FAIL back_to_back_gap: got %0d want 4", t_second - t_first);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL back_to_back_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_emit;
    int n;
    bit seen;
    @(negedge clk);
    stamp_x = 10'd100; stamp_y = 9'd100; radius = 5'd1; color = 12'h0aa;
    pix_ready = 1'b0; stamp_req = 1'b1;
    @(negedge clk);
    stamp_req = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 50 && !seen; cyc++) begin
      if (pix_valid === 1'b1) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reset_emit_reach: got no valid want valid"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pix_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || pix_x !== '0 || pix_y !== '0) begin
      errors++;
      $display("FAIL reset_mid_emit: got v=%b busy=%b done=%b (%0d,%0d) want 0 0 0 (0,0)",
               pix_valid, busy, done, pix_x, pix_y);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_stamp(100, 100, 1, 12'h0aa, 1, 0, "after_reset", n);
  endtask

  initial begin
    test_reset();
    test_single_point();
    test_small_disc();
    test_corner_clip();
    test_large_stall();
    test_clamp_ignore_req();
    test_offscreen();
    test_random();
    test_back_to_back();
    test_reset_mid_emit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
